// File: rtl/mc_seq_ctrl.sv
// mc_seq_ctrl: multi-cycle sequencer for the mini RV32I core.
// Walks IDLE/FETCH/DECODE/EXEC/MEM/WB for each instruction, owns the single
// memory port valid/ready handshake, the PC/IR/regfile write strobes, the
// retired-instruction counter and a sticky trap state.
//
// Memory handshake: mem_req is the request valid. mem_sel and mem_we are
// decoded from the registered state only, so they hold steady for as long as
// mem_req waits. A transfer completes on any cycle where mem_req and mem_ready
// are both high. mem_ready has no effect while mem_req is low.
module mc_seq_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             br_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_sel,
  output logic             mem_we,
  output logic             ir_we,
  output logic             reg_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic [2:0]       state,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd7
  } state_e;

  // Instruction class captured in DECODE. Later states use this class
  // instead of the raw opcode.
  typedef enum logic [2:0] {
    C_ALU   = 3'd0,
    C_LOAD  = 3'd1,
    C_STORE = 3'd2,
    C_BR    = 3'd3,
    C_JAL   = 3'd4,
    C_JALR  = 3'd5
  } class_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  // The wait counter counts 0..TIMEOUT-1. When it is at its last value and
  // mem_ready is still low, the request has timed out.
  localparam int              WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  state_e             state_q, state_d;
  class_e             cls_q, cls_d;
  logic [1:0]         cause_q, cause_d;
  logic [CNT_W-1:0]   instret_q, instret_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;

  class_e             dec_cls;
  logic               dec_legal;
  logic               timeout_hit;
  logic               retire;

  // Opcode decode: checks whether the opcode is legal and sorts it into a class.
  always_comb begin
    dec_cls   = C_ALU;
    dec_legal = 1'b1;
    case (opcode)
      OP_R, OP_I, OP_LUI, OP_AUIPC: dec_cls = C_ALU;
      OP_LOAD:                      dec_cls = C_LOAD;
      OP_STORE:                     dec_cls = C_STORE;
      OP_BR:                        dec_cls = C_BR;
      OP_JAL:                       dec_cls = C_JAL;
      OP_JALR:                      dec_cls = C_JALR;
      default:                      dec_legal = 1'b0;
    endcase
  end

  // Next-state logic, including the retire decision and timeout tracking.
  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    cause_d     = cause_q;
    instret_d   = instret_q;
    wait_d      = wait_q;
    retire      = 1'b0;
    timeout_hit = (TIMEOUT != 0) && (wait_q == WAIT_LAST);
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
          wait_d  = '0;
        end
      end
      S_FETCH: begin
        // A mem_ready in the final allowed cycle still completes the fetch.
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DECODE: begin
        if (dec_legal) begin
          cls_d   = dec_cls;
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      S_EXEC: begin
        case (cls_q)
          C_LOAD, C_STORE: begin
            state_d = S_MEM;
            wait_d  = '0;
          end
          C_BR:    retire  = 1'b1;
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (cls_q == C_STORE) retire = 1'b1;
          else                  state_d = S_WB;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB:    retire  = 1'b1;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase

    // Retire: count the instruction, then sample run to pick the next state.
    if (retire) begin
      instret_d = instret_q + 1'b1;
      state_d   = run ? S_FETCH : S_IDLE;
      wait_d    = '0;
    end
  end

  // Sequencer state registers. An async reset returns every register to idle values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cls_q     <= C_ALU;
      cause_q   <= CAUSE_NONE;
      instret_q <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
      wait_q    <= wait_d;
    end
  end

  // Strobe decode. The memory-side strobes depend only on the registered
  // state (Moore). ir_we, pc_we and pc_sel also use same-cycle inputs.
  always_comb begin
    mem_req = (state_q == S_FETCH) || (state_q == S_MEM);
    mem_sel = (state_q == S_MEM);
    mem_we  = (state_q == S_MEM) && (cls_q == C_STORE);
    ir_we   = (state_q == S_FETCH) && mem_ready;
    reg_we  = (state_q == S_WB);
    pc_we   = retire;
    pc_sel  = 2'd0;
    if (state_q == S_EXEC && cls_q == C_BR) begin
      pc_sel = br_taken ? 2'd1 : 2'd0;
    end else if (state_q == S_WB) begin
      if (cls_q == C_JAL)       pc_sel = 2'd1;
      else if (cls_q == C_JALR) pc_sel = 2'd2;
    end
  end

  assign state      = state_q;
  assign trap_cause = cause_q;
  assign instret    = instret_q;

endmodule
